health_meter: RTL and testbench

Parametrised per-player health tracker for the fighting-game datapath. It sits between the hit-resolution logic and the HUD/round controller. It keeps CH independent health values and applies synchronous damage strobes, with guard (chip damage), post-hit invulnerability frames and healing. It latches a round-over flag with a loser mask that can flag a double KO, and freezes all updates until the next round start.

---
 rtl/health_meter_if.sv | 26 ++
 rtl/health_meter.sv | 97 +++++++++
 tb/tb_health_meter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/health_meter_if.sv
// Hit-resolution / HUD side of the per-player health tracker.
interface health_meter_if #(
   parameter int CH = 2,
   parameter int W  = 8
);
   logic              round_start;
   logic [CH-1:0]     hit_valid;
   logic [CH*W-1:0]   hit_dmg;
   logic [CH-1:0]     guard;
   logic [CH-1:0]     heal_valid;
   logic [W-1:0]      heal_amt;
   logic [CH*W-1:0]   health;
   logic [CH-1:0]     invuln;
   logic              over;
   logic [CH-1:0]     loser;

   modport master (
      output round_start, hit_valid, hit_dmg, guard, heal_valid, heal_amt,
      input  health, invuln, over, loser
   );

   modport slave (
      input  round_start, hit_valid, hit_dmg, guard, heal_valid, heal_amt,
      output health, invuln, over, loser
   );
endinterface

// File: rtl/health_meter.sv
// Per-player health tracker: damage with guard and invulnerability frames,
// clamped healing, and a sticky round-over flag with loser mask.
module health_meter #(
   parameter int CH          = 2,
   parameter int W           = 8,
   parameter int INIT        = 100,
   parameter int IFRAMES     = 8,
   parameter int GUARD_SHIFT = 2
) (
   input logic          clk,
   input logic          reset,
   health_meter_if.slave bus
);
   localparam int CW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
   localparam logic [W-1:0]  INIT_V = W'(INIT);
   localparam logic [CW-1:0] IF_V   = CW'(IFRAMES);

   typedef enum logic {ST_PLAY, ST_OVER} state_t;

   state_t          state;
   logic [W-1:0]    hp_q  [CH];
   logic [CW-1:0]   cnt_q [CH];
   logic [CH-1:0]   loser_q;

   logic [W-1:0]    hp_d  [CH];
   logic [CW-1:0]   cnt_d [CH];
   logic [CH-1:0]   zero_d;

   always_comb begin
      zero_d = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         logic [W-1:0] dmg;
         logic [W-1:0] eff;
         logic [W-1:0] post;
         logic [W:0]   sum;
         logic         applied;
         dmg  = bus.hit_dmg[i*W +: W];
         eff  = bus.guard[i] ? (dmg >> GUARD_SHIFT) : dmg;
         // A counter of 1 expires on this edge, so the hit landing on it is
         // accepted: the window then spans exactly IFRAMES cycles.
         applied = bus.hit_valid[i] && (cnt_q[i] <= CW'(1)) &&
                   (state == ST_PLAY) && (eff != '0);
         post = hp_q[i];
         if (applied)
            post = (eff >= hp_q[i]) ? '0 : hp_q[i] - eff;
         sum     = {1'b0, post} + {1'b0, bus.heal_amt};
         hp_d[i] = post;
         if (bus.heal_valid[i] && (state == ST_PLAY) && (post != '0))
            hp_d[i] = (sum > {1'b0, INIT_V}) ? INIT_V : sum[W-1:0];
         cnt_d[i] = cnt_q[i];
         if (applied)
            cnt_d[i] = IF_V;
         else if (cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - CW'(1);
         zero_d[i] = (hp_d[i] == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_PLAY;
         loser_q <= '0;
         for (int unsigned i = 0; i < CH; i++) begin
            hp_q[i]  <= INIT_V;
            cnt_q[i] <= '0;
         end
      end else if (bus.round_start) begin
         state   <= ST_PLAY;
         loser_q <= '0;
         for (int unsigned i = 0; i < CH; i++) begin
            hp_q[i]  <= INIT_V;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            hp_q[i]  <= hp_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         if ((state == ST_PLAY) && (|zero_d)) begin
            state   <= ST_OVER;
            loser_q <= zero_d;
         end
      end
   end

   always_comb begin
      bus.health = '0;
      bus.invuln = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         bus.health[i*W +: W] = hp_q[i];
         bus.invuln[i]        = (cnt_q[i] != '0);
      end
   end

   assign bus.over  = (state == ST_OVER);
   assign bus.loser = loser_q;
endmodule

// File: tb/tb_health_meter.sv
// Scenario bench for health_meter (CH=2, W=8, INIT=100, IFRAMES=4, GUARD_SHIFT=2).
module tb_health_meter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   health_meter_if #(.CH(2), .W(8)) bus ();

   health_meter #(
      .CH(2), .W(8), .INIT(100), .IFRAMES(4), .GUARD_SHIFT(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] hv;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] g;
      logic [1:0] hlv;
      logic [7:0] amt;
      logic       rs;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [1:0] einv;
      logic       eov;
      logic [1:0] els;
   } step_t;

   typedef struct {
      string       name;
      logic [20:0] val;
   } exp_t;

   exp_t sb[$];

   function automatic step_t mk(logic [1:0] hv, logic [7:0] d0, logic [7:0] d1,
                                logic [1:0] g, logic [1:0] hlv, logic [7:0] amt,
                                logic rs, logic [7:0] e0, logic [7:0] e1,
                                logic [1:0] einv, logic eov, logic [1:0] els);
      step_t s;
      s.hv = hv; s.d0 = d0; s.d1 = d1; s.g = g; s.hlv = hlv; s.amt = amt;
      s.rs = rs; s.e0 = e0; s.e1 = e1; s.einv = einv; s.eov = eov; s.els = els;
      return s;
   endfunction

   function automatic logic [20:0] pack_exp(step_t s);
      return {s.e1, s.e0, s.einv, s.eov, s.els};
   endfunction

   function automatic logic [20:0] observed();
      return {bus.health, bus.invuln, bus.over, bus.loser};
   endfunction

   function automatic string fmt(logic [20:0] v);
      return $sformatf("h1=%0d h0=%0d inv=%b over=%b loser=%b",
                       v[20:13], v[12:5], v[4:3], v[2], v[1:0]);
   endfunction

   task automatic drive(step_t s);
      bus.hit_valid   = s.hv;
      bus.hit_dmg     = {s.d1, s.d0};
      bus.guard       = s.g;
      bus.heal_valid  = s.hlv;
      bus.heal_amt    = s.amt;
      bus.round_start = s.rs;
   endtask

   task automatic idle_inputs();
      bus.hit_valid = '0; bus.hit_dmg = '0; bus.guard = '0;
      bus.heal_valid = '0; bus.heal_amt = '0; bus.round_start = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [20:0] obs;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back('{name: "reset_held", val: {8'd100, 8'd100, 2'b00, 1'b0, 2'b00}});
      e = sb.pop_front(); obs = observed(); checks++;
      if (obs !== e.val) begin
         errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
      end
      reset = 1'b0;
      sb.push_back('{name: "reset_release", val: {8'd100, 8'd100, 2'b00, 1'b0, 2'b00}});
      @(posedge clk); #1;
      e = sb.pop_front(); obs = observed(); checks++;
      if (obs !== e.val) begin
         errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
      end
   endtask

   task automatic test_iframes();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b01, 30, 0, 0, 0, 0, 0, 70, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b01, 10, 0, 0, 0, 0, 0, 70, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 70, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 70, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b01, 10, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b00, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("iframes[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   task automatic test_guard();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b10, 0, 20, 2'b10, 0, 0, 0, 60, 95, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 95, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 95, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 95, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 95, 2'b00, 0, 0));
      st.push_back(mk(2'b10, 0, 3, 2'b10, 0, 0, 0, 60, 95, 2'b00, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("guard[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   task automatic test_heal();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b00, 0, 0, 0, 2'b10, 20, 0, 60, 100, 2'b00, 0, 0));
      st.push_back(mk(2'b10, 0, 30, 0, 2'b10, 10, 0, 60, 80, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 2'b01, 20, 0, 80, 80, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 2'b10, 255, 0, 80, 100, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 80, 100, 2'b10, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 80, 100, 2'b00, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("heal[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   task automatic test_exact_ko();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b01, 20, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 60, 100, 2'b00, 0, 0));
      st.push_back(mk(2'b01, 60, 0, 0, 0, 0, 0, 0, 100, 2'b01, 1, 2'b01));
      st.push_back(mk(2'b10, 0, 40, 0, 2'b11, 50, 0, 0, 100, 2'b01, 1, 2'b01));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 100, 2'b01, 1, 2'b01));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 100, 2'b01, 1, 2'b01));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 100, 2'b00, 1, 2'b01));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("exact_ko[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   task automatic test_restart();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b10, 0, 40, 0, 0, 0, 1, 100, 100, 2'b00, 0, 0));
      st.push_back(mk(2'b01, 30, 0, 0, 0, 0, 0, 70, 100, 2'b01, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("restart[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
      // Pulse reset between clock edges; outputs must clear with no edge.
      reset = 1'b1;
      #2;
      sb.push_back('{name: "async_reset", val: {8'd100, 8'd100, 2'b00, 1'b0, 2'b00}});
      e = sb.pop_front(); obs = observed(); checks++;
      if (obs !== e.val) begin
         errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
      end
      #1;
      reset = 1'b0;
      sb.push_back('{name: "after_async_reset", val: {8'd100, 8'd100, 2'b00, 1'b0, 2'b00}});
      @(posedge clk); #1;
      e = sb.pop_front(); obs = observed(); checks++;
      if (obs !== e.val) begin
         errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
      end
   endtask

   task automatic test_double_ko();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b11, 90, 95, 0, 0, 0, 0, 10, 5, 2'b11, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 5, 2'b11, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 5, 2'b11, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 5, 2'b11, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 5, 2'b00, 0, 0));
      st.push_back(mk(2'b11, 10, 200, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b11));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 1, 100, 100, 2'b00, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("double_ko[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   task automatic test_heal_ko();
      step_t st[$];
      exp_t e;
      logic [20:0] obs;
      st.push_back(mk(2'b01, 95, 0, 0, 0, 0, 0, 5, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 100, 2'b01, 0, 0));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 100, 2'b00, 0, 0));
      st.push_back(mk(2'b01, 5, 0, 0, 2'b01, 50, 0, 0, 100, 2'b01, 1, 2'b01));
      st.push_back(mk(2'b00, 0, 0, 0, 0, 0, 1, 100, 100, 2'b00, 0, 0));
      foreach (st[k]) begin
         sb.push_back('{name: $sformatf("heal_ko[%0d]", k), val: pack_exp(st[k])});
         drive(st[k]); @(posedge clk); #1;
         e = sb.pop_front(); obs = observed(); checks++;
         if (obs !== e.val) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs), fmt(e.val));
         end
      end
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_iframes();
      test_guard();
      test_heal();
      test_exact_ko();
      test_restart();
      test_double_ko();
      test_heal_ko();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
